// File: rtl/adc_serial_reader.sv
// Periodic reader for an MCP3201-style serial ADC (SPI mode 0, read-only).
// Each conversion is deserialised MSB-first and presented as Dout with a one-cycle EN strobe.
module adc_serial_reader #(
  parameter int N             = 12,
  parameter int LEAD_BITS     = 3,
  parameter int CLK_DIV       = 8,
  parameter int SAMPLE_PERIOD = 1000,
  parameter bit CHECK_PERIOD  = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         miso,
  output logic         cs_n,
  output logic         sclk,
  output logic [N-1:0] Dout,
  output logic         EN,
  output logic         busy,
  output logic         overrun
);

  localparam int BITS     = LEAD_BITS + N;
  localparam int CONV_LEN = CLK_DIV * (2 * BITS + 2);
  localparam int CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W    = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(BITS - 1);
  localparam logic [BIT_W-1:0] FIRST_DATA  = BIT_W'(LEAD_BITS);

  // A period shorter than a conversion would make every other tick an overrun.
  if (CLK_DIV < 1 || (CHECK_PERIOD && (SAMPLE_PERIOD <= CONV_LEN + 1))) begin : g_param_check
    $error("adc_serial_reader: CLK_DIV must be >= 1 and SAMPLE_PERIOD > CONV_LEN+1");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [N-1:0]     shreg;
  logic             tick;

  assign tick = run && (count == PERIOD_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || (count == PERIOD_LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // div_cnt times every phase (setup, each sclk half, hold) and always wraps to 0 on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      Dout    <= '0;
      EN      <= 1'b0;
      overrun <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      EN      <= 1'b0;
      overrun <= tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (tick) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            div_cnt <= '0;
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (bit_cnt >= FIRST_DATA) begin
                shreg <= {shreg[N-2:0], miso};
              end
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= IDLE;
            cs_n    <= 1'b1;
            Dout    <= shreg;
            EN      <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: three instances (nominal, short period, CLK_DIV=1) fed by a
// behavioural MCP3201-style ADC; words fed to the ADC are scoreboarded against Dout on EN.
module tb_adc_serial_reader;

  typedef struct {
    int          inst;
    logic [11:0] dout;
    int          cyc;
    int          rises;
    int          cslen;
    int          gmin;
    int          gmax;
  } obs_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [2:0]  run_v  = '0;
  logic [2:0]  miso_v = '0;
  logic [2:0]  cs_n_v, sclk_v, en_v, busy_v, ovr_v;
  logic [11:0] dout_v [3];

  int cyc          = 0;
  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] word_q [$];
  logic [11:0] exp_q  [$];
  obs_t        obs_q  [$];
  int          obs_rd  = 0;
  int          word_rd = 0;

  logic [11:0] cur [3] = '{default: 12'h000};
  int          pos [3], rises [3], cslen [3], gmin [3], gmax [3];
  int          last_rise [3], falls [3], ovr_cnt [3];
  int          sclk_viol = 0;
  int          en_viol   = 0;
  logic [2:0]  cs_prev = '1, sclk_prev = '0, en_prev = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int DIV = (g == 2) ? 1 : 2;
    localparam int PER = (g == 1) ? 40 : 100;
    adc_serial_reader #(
      .N(12), .LEAD_BITS(3), .CLK_DIV(DIV), .SAMPLE_PERIOD(PER), .CHECK_PERIOD(g != 1)
    ) dut (
      .clk(clk), .reset(reset), .run(run_v[g]), .miso(miso_v[g]),
      .cs_n(cs_n_v[g]), .sclk(sclk_v[g]), .Dout(dout_v[g]), .EN(en_v[g]),
      .busy(busy_v[g]), .overrun(ovr_v[g])
    );
  end

  // Lead bits are driven high so a reader that keeps them corrupts the word.
  function automatic logic adc_bit(input logic [11:0] w, input int p);
    if (p < 3) return 1'b1;
    if (p < 15) return w[14 - p];
    return 1'b0;
  endfunction

  // ADC model plus monitor: data changes after sclk falls, stats are gathered per conversion.
  always @(negedge clk) begin
    obs_t o;
    int   gap;
    for (int k = 0; k < 3; k++) begin
      if (!cs_n_v[k] && cs_prev[k]) begin
        cur[k] = (word_rd < word_q.size()) ? word_q[word_rd] : 12'h000;
        word_rd++;
        pos[k] = 0; rises[k] = 0; cslen[k] = 0; gmin[k] = 1000000; gmax[k] = 0;
        falls[k]++;
      end
      if (!cs_n_v[k]) begin
        cslen[k]++;
        if (sclk_v[k] && !sclk_prev[k]) begin
          if (rises[k] > 0) begin
            gap = cyc - last_rise[k];
            if (gap < gmin[k]) gmin[k] = gap;
            if (gap > gmax[k]) gmax[k] = gap;
          end
          last_rise[k] = cyc;
          rises[k]++;
        end
        if (!sclk_v[k] && sclk_prev[k]) pos[k]++;
      end else if (sclk_v[k]) begin
        sclk_viol++;
      end
      if (en_v[k]) begin
        if (en_prev[k]) en_viol++;
        o.inst = k; o.dout = dout_v[k]; o.cyc = cyc; o.rises = rises[k];
        o.cslen = cslen[k]; o.gmin = gmin[k]; o.gmax = gmax[k];
        obs_q.push_back(o);
      end
      if (ovr_v[k]) ovr_cnt[k]++;
      miso_v[k]    = adc_bit(cur[k], pos[k]);
      cs_prev[k]   = cs_n_v[k];
      sclk_prev[k] = sclk_v[k];
      en_prev[k]   = en_v[k];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic wait_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [11:0] word);
    word_q.push_back(word);
    exp_q.push_back(word);
  endtask

  task automatic wait_obs(input string tag, input int budget, output obs_t o);
    int n = 0;
    o.inst = -1; o.dout = 'x; o.cyc = 0; o.rises = 0; o.cslen = 0; o.gmin = 0; o.gmax = 0;
    while (obs_rd >= obs_q.size() && n < budget) begin
      wait_cycle();
      n++;
    end
    check_output({tag, " EN arrived"}, 32'(obs_rd < obs_q.size()), 32'd1);
    if (obs_rd < obs_q.size()) begin
      o = obs_q[obs_rd];
      obs_rd++;
    end
  endtask

  task automatic wait_cs_low(input string tag, input int k, input int budget);
    int n = 0;
    while (cs_n_v[k] && n < budget) begin
      wait_cycle();
      n++;
    end
    check_output({tag, " cs_n fell"}, 32'(cs_n_v[k]), 32'd0);
  endtask

  task automatic wait_rises(input string tag, input int k, input int target, input int budget);
    int n = 0;
    while (rises[k] < target && n < budget) begin
      wait_cycle();
      n++;
    end
    check_output({tag, " sclk rises reached"}, 32'(rises[k] >= target), 32'd1);
  endtask

  task automatic check_conv(input string tag, input obs_t o, input int k,
                            input int conv, input int gap);
    logic [11:0] expected;
    expected = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
    check_output({tag, " instance"}, 32'(o.inst), 32'(k));
    check_output({tag, " Dout"}, 32'(o.dout), 32'(expected));
    check_output({tag, " sclk rises"}, 32'(o.rises), 32'd15);
    check_output({tag, " cs_n low cycles"}, 32'(o.cslen), 32'(conv));
    check_output({tag, " sclk period min"}, 32'(o.gmin), 32'(gap));
    check_output({tag, " sclk period max"}, 32'(o.gmax), 32'(gap));
  endtask

  initial begin
    obs_t o;
    int   prev_cyc;
    int   run_cyc;
    int   falls_snap;

    $display("[TB] reset state");
    repeat (3) wait_cycle();
    check_output("reset cs_n", 32'(cs_n_v), 32'h7);
    check_output("reset sclk", 32'(sclk_v), 32'h0);
    check_output("reset EN", 32'(en_v), 32'h0);
    check_output("reset busy", 32'(busy_v), 32'h0);
    check_output("reset overrun", 32'(ovr_v), 32'h0);
    check_output("reset Dout", 32'(dout_v[0]), 32'h0);
    reset = 1'b0;
    repeat (5) wait_cycle();
    check_output("idle cs_n", 32'(cs_n_v), 32'h7);

    $display("[TB] nominal conversions, CLK_DIV=2 period 100");
    apply_stimulus(12'hA5C);
    apply_stimulus(12'h000);
    apply_stimulus(12'hFFF);
    apply_stimulus(12'h801);
    run_v[0] = 1'b1;
    run_cyc  = cyc;
    wait_obs("t1", 400, o);
    check_conv("t1", o, 0, 64, 4);
    check_output("t1 run to EN latency", 32'(o.cyc - run_cyc), 32'd164);
    prev_cyc = o.cyc;
    for (int i = 0; i < 3; i++) begin
      wait_obs("t2", 200, o);
      check_conv("t2", o, 0, 64, 4);
      check_output("t2 EN spacing", 32'(o.cyc - prev_cyc), 32'd100);
      prev_cyc = o.cyc;
    end

    $display("[TB] reset during shift");
    apply_stimulus(12'h3C7);
    wait_cs_low("t3", 0, 200);
    wait_rises("t3", 0, 7, 100);
    reset = 1'b1;
    #1;
    check_output("t3 cs_n in reset", 32'(cs_n_v[0]), 32'd1);
    check_output("t3 sclk in reset", 32'(sclk_v[0]), 32'd0);
    check_output("t3 Dout in reset", 32'(dout_v[0]), 32'h0);
    check_output("t3 busy in reset", 32'(busy_v[0]), 32'd0);
    void'(exp_q.pop_back());
    repeat (3) wait_cycle();
    reset   = 1'b0;
    run_cyc = cyc;
    apply_stimulus(12'h6B2);
    wait_obs("t3", 400, o);
    check_conv("t3", o, 0, 64, 4);
    check_output("t3 release to EN latency", 32'(o.cyc - run_cyc), 32'd164);

    $display("[TB] run dropped mid-conversion");
    apply_stimulus(12'h19E);
    wait_cs_low("t4", 0, 200);
    wait_rises("t4", 0, 5, 100);
    run_v[0] = 1'b0;
    wait_obs("t4", 200, o);
    check_conv("t4", o, 0, 64, 4);
    falls_snap = falls[0];
    repeat (300) wait_cycle();
    check_output("t4 no new cs_n fall", 32'(falls[0]), 32'(falls_snap));
    check_output("t4 no extra EN", 32'(obs_q.size()), 32'(obs_rd));
    check_output("t4 Dout held", 32'(dout_v[0]), 32'h19E);
    check_output("t4 no overrun", 32'(ovr_cnt[0]), 32'd0);

    $display("[TB] short period, overrun");
    apply_stimulus(12'h123);
    apply_stimulus(12'hABC);
    apply_stimulus(12'hF0F);
    run_v[1] = 1'b1;
    run_cyc  = cyc;
    wait_obs("t5", 300, o);
    check_conv("t5", o, 1, 64, 4);
    check_output("t5 run to EN latency", 32'(o.cyc - run_cyc), 32'd104);
    prev_cyc = o.cyc;
    for (int i = 0; i < 2; i++) begin
      wait_obs("t5", 200, o);
      check_conv("t5", o, 1, 64, 4);
      check_output("t5 EN spacing", 32'(o.cyc - prev_cyc), 32'd80);
      prev_cyc = o.cyc;
    end
    run_v[1] = 1'b0;
    repeat (100) wait_cycle();
    check_output("t5 overrun pulse cycles", 32'(ovr_cnt[1]), 32'd3);
    check_output("t5 idle after stop", 32'(busy_v[1]), 32'd0);

    $display("[TB] CLK_DIV=1");
    apply_stimulus(12'h555);
    apply_stimulus(12'hAAA);
    run_v[2] = 1'b1;
    run_cyc  = cyc;
    wait_obs("t6", 300, o);
    check_conv("t6", o, 2, 32, 2);
    check_output("t6 run to EN latency", 32'(o.cyc - run_cyc), 32'd132);
    prev_cyc = o.cyc;
    wait_obs("t6", 200, o);
    check_conv("t6", o, 2, 32, 2);
    check_output("t6 EN spacing", 32'(o.cyc - prev_cyc), 32'd100);
    run_v[2] = 1'b0;
    repeat (50) wait_cycle();

    check_output("sclk high with cs_n high", 32'(sclk_viol), 32'd0);
    check_output("EN on consecutive cycles", 32'(en_viol), 32'd0);
    check_output("unconsumed expectations", 32'(exp_q.size()), 32'd0);
    check_output("conversions vs words", 32'(word_rd), 32'(word_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
